regfile_sequencer: RTL
======================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameters: none; all widths are fixed at 4-bit data and 2-bit register address.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr_op  input  3  ALU opcode; 3'b111 = LOADI (write immediate, no ALU).
REQ-007 instr_rd  input  2  destination register.
REQ-008 instr_rs1  input  2  source register A.
REQ-009 instr_rs2  input  2  source register B.
REQ-010 instr_imm  input  4  immediate for LOADI.
REQ-011 rd1, rd2  output  2 each  register-file read addresses.
REQ-012 data_out1, data_out2  input  4 each  register-file read data (combinational from rd1/rd2).
REQ-013 wr  output  2  register-file write address.
REQ-014 write_enable  output  1  register-file write strobe; the write takes effect at the next rising clk.
REQ-015 data_in  output  4  register-file write data.
REQ-016 alu_op  output  3  ALU opcode.
REQ-017 alu_a, alu_b  output  4 each  ALU operands.
REQ-018 alu_result  input  4  ALU result (combinational).
REQ-019 alu_carry  input  1  ALU carry/borrow out.
REQ-020 busy  output  1  FSM is not IDLE, or the queue is non-empty.
REQ-021 done  output  1  one-cycle pulse, high during the WRITE cycle of each instruction.
REQ-022 carry_flag, zero_flag  output  1 each  flags of the last completed ALU instruction.

Function
REQ-023 The block SHALL contain a 2-entry FIFO of instructions {op, rd, rs1, rs2, imm}.
REQ-024 instr_ready SHALL equal !fifo_full.
REQ-025 An instruction SHALL be pushed on any cycle with instr_valid && instr_ready, including while the FSM is active.
REQ-026 The FSM SHALL have the states IDLE, READ, EXEC and WRITE.
REQ-027 IDLE: if the FIFO is non-empty, pop the head into the current-instruction register; go to WRITE if op==111, else to READ.
REQ-028 A push into an empty FIFO SHALL be poppable no earlier than the next cycle (no bypass).
REQ-029 READ: drive rd1=rs1 and rd2=rs2; latch data_out1 into opA and data_out2 into opB at the end of the cycle; go to EXEC.
REQ-030 EXEC: drive alu_op=op, alu_a=opA, alu_b=opB; latch alu_result into res and alu_carry into cy at the end of the cycle; go to WRITE.
REQ-031 WRITE: drive write_enable=1, wr=rd, and data_in=res (ALU op) or imm (LOADI); pulse done.
REQ-032 On leaving WRITE for an ALU op, carry_flag SHALL take cy and zero_flag SHALL take (res==0); LOADI SHALL leave both flags unchanged.
REQ-033 From WRITE, the FSM SHALL pop the next instruction directly if the FIFO is non-empty, otherwise return to IDLE.
REQ-034 Timing: an ALU op popped in IDLE at cycle N SHALL occupy READ at N+1, EXEC at N+2 and WRITE at N+3; a LOADI popped at N SHALL occupy WRITE at N+1.
REQ-035 Back-to-back throughput: an ALU op SHALL take 3 cycles and a LOADI 1 cycle after the first instruction.
REQ-036 Read-after-write needs no stall: the WRITE edge precedes the next READ cycle.
REQ-037 Outside WRITE, write_enable SHALL be 0; outside READ and EXEC, rd1, rd2, alu_a, alu_b, alu_op and data_in SHALL hold their last values.
REQ-038 A simultaneous push and pop SHALL be allowed when the FIFO is not full; occupancy stays unchanged.

Reset
REQ-039 While reset is high at a clk edge: FSM->IDLE, FIFO emptied, done=0, write_enable=0, busy=0, flags=0, rd1=rd2=wr=0, data_in=alu_a=alu_b=0, alu_op=0.
REQ-040 Reset SHALL override a concurrent push.
REQ-041 Reset during READ or EXEC SHALL abort the instruction with no write.
REQ-042 Reset during WRITE SHALL suppress the write on that edge.
REQ-043 instr_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-044 LOADI r2,imm=4'hA at cycle 0 -> WRITE at cycle 2 with wr=2, data_in=A, write_enable=1, done=1; flags unchanged.
REQ-045 r0=3, r1=5, op ADD, rd=r3 -> rd1=0, rd2=1 in READ; alu_a=3, alu_b=5 in EXEC; WRITE wr=3, data_in=8; carry=0, zero=0.
REQ-046 r0=F, r1=1, ADD into r0, then SUB r0-r0 into r1 -> first data_in=0 with carry=1, zero=1; second READ sees r0=0 (no stall).
REQ-047 Three instructions offered back-to-back while busy -> instr_ready drops after the 2 queued entries; no instruction is lost or duplicated; done pulses in order.
REQ-048 Assert reset in the EXEC cycle of an ADD -> no write_enable pulse; the FIFO is empty and all outputs are 0 the next cycle.
REQ-049 Interleave LOADI and ADD with continuous valid -> done spacing is 1 cycle after LOADI and 3 cycles after ADD; write addresses match issue order.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: queues up to two instructions, then reads operands from an
// external register file, runs them through an external ALU and writes back.
//
// state | meaning
// IDLE  | no instruction in flight; pops the queue head when one is available
// READ  | rd1/rd2 presented; operands captured into alu_a/alu_b at end of cycle
// EXEC  | operands and opcode presented to the ALU; result captured at end
// WRITE | write strobe, write address and data valid; done pulses; flags on exit
module regfile_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [1:0] instr_rd,
  input  logic [1:0] instr_rs1,
  input  logic [1:0] instr_rs2,
  input  logic [3:0] instr_imm,
  output logic [1:0] rd1,
  output logic [1:0] rd2,
  input  logic [3:0] data_out1,
  input  logic [3:0] data_out2,
  output logic [1:0] wr,
  output logic       write_enable,
  output logic [3:0] data_in,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic       busy,
  output logic       done,
  output logic       carry_flag,
  output logic       zero_flag
);

  localparam logic [2:0] OP_LOADI = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] imm;
  } instr_t;

  state_t     state;
  instr_t     fifo_mem [2];
  logic       fifo_wp;
  logic       fifo_rp;
  logic [1:0] fifo_cnt;
  instr_t     head;
  instr_t     incoming;
  logic       fifo_full;
  logic       push;
  logic       pop;
  logic [2:0] cur_op;
  logic [1:0] cur_rd;
  logic [3:0] res;
  logic       cy;
  logic       we_q;

  assign incoming    = {instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm};
  assign head        = fifo_mem[fifo_rp];
  assign fifo_full   = (fifo_cnt == 2'd2);
  assign instr_ready = !fifo_full;
  assign push        = instr_valid && !fifo_full;
  // Pop only looks at the registered count, so a same-cycle push is never bypassed.
  assign pop         = ((state == IDLE) || (state == WRITE)) && (fifo_cnt != 2'd0);
  assign busy        = (state != IDLE) || (fifo_cnt != 2'd0);
  // The register file samples the strobe on the same edge reset is seen,
  // so the strobe is gated here to block a write when reset lands in WRITE.
  assign write_enable = we_q && !reset;

  // Queue, sequencing FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_cnt   <= 2'd0;
      cur_op     <= 3'd0;
      cur_rd     <= 2'd0;
      res        <= 4'd0;
      cy         <= 1'b0;
      we_q       <= 1'b0;
      done       <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      rd1        <= 2'd0;
      rd2        <= 2'd0;
      wr         <= 2'd0;
      data_in    <= 4'd0;
      alu_op     <= 3'd0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
    end else begin
      we_q <= 1'b0;
      done <= 1'b0;

      if (push) begin
        fifo_mem[fifo_wp] <= incoming;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      case (state)
        READ: begin
          alu_a  <= data_out1;
          alu_b  <= data_out2;
          alu_op <= cur_op;
          state  <= EXEC;
        end
        EXEC: begin
          res     <= alu_result;
          cy      <= alu_carry;
          data_in <= alu_result;
          wr      <= cur_rd;
          we_q    <= 1'b1;
          done    <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          if (cur_op != OP_LOADI) begin
            carry_flag <= cy;
            zero_flag  <= (res == 4'd0);
          end
          if (!pop) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase

      // Launch the queue head from IDLE or straight out of WRITE.
      if (pop) begin
        cur_op <= head.op;
        cur_rd <= head.rd;
        if (head.op == OP_LOADI) begin
          wr      <= head.rd;
          data_in <= head.imm;
          we_q    <= 1'b1;
          done    <= 1'b1;
          state   <= WRITE;
        end else begin
          rd1   <= head.rs1;
          rd2   <= head.rs2;
          state <= READ;
        end
      end
    end
  end

endmodule
